switch_conf_sequencer: RTL and testbench

- Downstream of the per-switch configuration reader.
- Consumes its write strobes (pc_max, pc_loop, net_mem) and stores per-thread switch configuration words in a local conf memory.
- At run time it interleaves threads round-robin, one thread per enabled cycle, and emits each thread's current switch configuration word to the switch datapath.
- Each thread has its own program counter, which loops over the window [pc_loop..pc_max].

---
 rtl/switch_conf_sequencer_pkg.sv | 14 +
 rtl/switch_conf_mem.sv | 39 +++
 rtl/switch_conf_sequencer.sv | 95 +++++++++
 tb/tb_switch_conf_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_conf_sequencer_pkg.sv
// Shared definitions for the switch configuration sequencer: conf opcodes
// issued by the upstream reader and default datapath widths.
package switch_conf_sequencer_pkg;

    localparam int unsigned THREAD_WIDTH_DEF = 3;
    localparam int unsigned CONF_WIDTH_DEF   = 24;

    typedef enum logic [3:0] {
        SET_NET_PC_MAX  = 4'd8,
        SET_NET_PC_LOOP = 4'd9,
        NET_SWITCH      = 4'd10
    } conf_op_e;

endpackage

// File: rtl/switch_conf_mem.sv
// Simple dual-port conf store: one write port, one registered read port.
// A same-address read and write returns the previous word.
module switch_conf_mem
    import switch_conf_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH_WIDTH = 4,
    parameter int unsigned DATA_WIDTH  = CONF_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic [DEPTH_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]  wdata_i,
    input  logic                   re_i,
    input  logic [DEPTH_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]  rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array deliberately has no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/switch_conf_sequencer.sv
// Round-robin per-thread switch configuration sequencer: each enabled cycle
// visits one thread, emits its current conf word and steps its looping PC.
module switch_conf_sequencer
    import switch_conf_sequencer_pkg::*;
#(
    parameter int unsigned NUM_THREADS  = 8,
    parameter int unsigned THREAD_WIDTH = THREAD_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH   = 1,
    parameter int unsigned CONF_WIDTH   = CONF_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   pc_max,
    input  logic                    pc_max_we,
    input  logic [ADDR_WIDTH-1:0]   pc_loop,
    input  logic                    pc_loop_we,
    input  logic [THREAD_WIDTH-1:0] thread_id,
    input  logic                    net_mem_we,
    input  logic [ADDR_WIDTH-1:0]   net_mem_waddr,
    input  logic [CONF_WIDTH-1:0]   net_mem_data,
    input  logic                    restart,
    input  logic                    en,
    output logic [CONF_WIDTH-1:0]   conf_out,
    output logic [THREAD_WIDTH-1:0] conf_thread,
    output logic                    conf_valid
);

    localparam int unsigned MEM_AW = THREAD_WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0]   pc_q      [NUM_THREADS];
    logic [ADDR_WIDTH-1:0]   pc_max_q  [NUM_THREADS];
    logic [ADDR_WIDTH-1:0]   pc_loop_q [NUM_THREADS];
    logic [THREAD_WIDTH-1:0] tp_q, tp_d;
    logic [THREAD_WIDTH-1:0] thread_q;
    logic                    valid_q;
    logic                    advance;
    logic [ADDR_WIDTH-1:0]   pc_cur, pc_d;

    // Loop window test uses equality only, so pc_loop > pc_max wraps around.
    always_comb begin
        advance = en && !restart;
        pc_cur  = pc_q[tp_q];
        pc_d    = (pc_cur == pc_max_q[tp_q]) ? pc_loop_q[tp_q] : pc_cur + ADDR_WIDTH'(1);
        tp_d    = tp_q + THREAD_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                pc_q[i]      <= '0;
                pc_max_q[i]  <= '0;
                pc_loop_q[i] <= '0;
            end
            tp_q     <= '0;
            thread_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (pc_max_we) begin
                pc_max_q[thread_id] <= pc_max;
            end
            if (pc_loop_we) begin
                pc_loop_q[thread_id] <= pc_loop;
            end
            valid_q <= advance;
            if (restart) begin
                for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                    pc_q[i] <= '0;
                end
                tp_q <= '0;
            end else if (en) begin
                pc_q[tp_q] <= pc_d;
                tp_q       <= tp_d;
                thread_q   <= tp_q;
            end
        end
    end

    switch_conf_mem #(
        .DEPTH_WIDTH (MEM_AW),
        .DATA_WIDTH  (CONF_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (net_mem_we),
        .waddr_i ({thread_id, net_mem_waddr}),
        .wdata_i (net_mem_data),
        .re_i    (advance),
        .raddr_i ({tp_q, pc_cur}),
        .rdata_o (conf_out)
    );

    assign conf_thread = thread_q;
    assign conf_valid  = valid_q;

endmodule

// File: tb/tb_switch_conf_sequencer.sv
// Scoreboard bench for switch_conf_sequencer: a reference model predicts each
// emitted conf word, scenario tasks add fixed expectations on top.
module tb_switch_conf_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:0]  pc_max = '0;
    logic        pc_max_we = 1'b0;
    logic [0:0]  pc_loop = '0;
    logic        pc_loop_we = 1'b0;
    logic [2:0]  thread_id = '0;
    logic        net_mem_we = 1'b0;
    logic [0:0]  net_mem_waddr = '0;
    logic [23:0] net_mem_data = '0;
    logic        restart = 1'b0;
    logic        en = 1'b0;
    logic [23:0] conf_out;
    logic [2:0]  conf_thread;
    logic        conf_valid;

    switch_conf_sequencer #(
        .NUM_THREADS  (8),
        .THREAD_WIDTH (3),
        .ADDR_WIDTH   (1),
        .CONF_WIDTH   (24)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_max        (pc_max),
        .pc_max_we     (pc_max_we),
        .pc_loop       (pc_loop),
        .pc_loop_we    (pc_loop_we),
        .thread_id     (thread_id),
        .net_mem_we    (net_mem_we),
        .net_mem_waddr (net_mem_waddr),
        .net_mem_data  (net_mem_data),
        .restart       (restart),
        .en            (en),
        .conf_out      (conf_out),
        .conf_thread   (conf_thread),
        .conf_valid    (conf_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  thr;
        logic [23:0] data;
        logic        known;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic        exp_v = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    logic [23:0] m_mem   [16];
    logic        m_known [16];
    logic [0:0]  m_pc    [8];
    logic [0:0]  m_max   [8];
    logic [0:0]  m_loop  [8];
    logic [2:0]  m_tp = '0;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_pc[i] = '0; m_max[i] = '0; m_loop[i] = '0;
        end
        m_tp = '0;
        sb.delete();
        exp_v = 1'b0;
    endtask

    // Predicts this cycle's effect, pushes the expected output, then clocks.
    task automatic tick();
        exp_t       e;
        logic [3:0] ra, wa;
        exp_v = en && !restart;
        if (exp_v) begin
            ra = {m_tp, m_pc[m_tp]};
            e.thr = m_tp; e.data = m_mem[ra]; e.known = m_known[ra];
            sb.push_back(e);
        end
        if (restart) begin
            for (int i = 0; i < 8; i++) m_pc[i] = '0;
            m_tp = '0;
        end else if (en) begin
            m_pc[m_tp] = (m_pc[m_tp] == m_max[m_tp]) ? m_loop[m_tp] : m_pc[m_tp] + 1'b1;
            m_tp = m_tp + 3'd1;
        end
        if (pc_max_we) m_max[thread_id] = pc_max;
        if (pc_loop_we) m_loop[thread_id] = pc_loop;
        if (net_mem_we) begin
            wa = {thread_id, net_mem_waddr};
            m_mem[wa] = net_mem_data; m_known[wa] = 1'b1;
        end
        @(posedge clk); #1;
        if (exp_v) begin
            if (sb.size() > 0) cur = sb.pop_front();
            else cur = '0;
        end
    endtask

    task automatic cfg(input logic [2:0] t, input logic [0:0] mx, input logic [0:0] lp);
        thread_id = t; pc_max = mx; pc_loop = lp; pc_max_we = 1'b1; pc_loop_we = 1'b1;
        tick();
        pc_max_we = 1'b0; pc_loop_we = 1'b0;
    endtask

    task automatic memwr(input logic [2:0] t, input logic [0:0] a, input logic [23:0] d);
        thread_id = t; net_mem_waddr = a; net_mem_data = d; net_mem_we = 1'b1;
        tick();
        net_mem_we = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (conf_valid !== 1'b0 || conf_out !== 24'h0 || conf_thread !== 3'd0)
            $display("FAIL reset_state got v=%b out=%h thr=%0d exp v=0 out=000000 thr=0", conf_valid, conf_out, conf_thread);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_known[i] = 1'b0;
        model_clear();
    endtask

    task automatic test_preload();
        for (int a = 0; a < 16; a++) begin
            memwr(3'(a >> 1), 1'(a), {8'(a), 16'hC0DE});
            n_total++;
            if (conf_valid !== 1'b0) $display("FAIL preload_valid got %b exp 0", conf_valid);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        int k = 0;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_total++;
            if (conf_valid !== exp_v) $display("FAIL rr_valid got %b exp %b", conf_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
                n_total++;
                if (conf_thread !== cur.thr || (cur.known && conf_out !== cur.data))
                    $display("FAIL rr_sb got thr=%0d out=%h exp thr=%0d out=%h", conf_thread, conf_out, cur.thr, cur.data);
                else n_pass++;
                n_total++;
                if (conf_thread !== 3'(k % 8)) $display("FAIL rr_order got %0d exp %0d", conf_thread, k % 8);
                else n_pass++;
                k++;
            end
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_thread0_alternate();
        logic [23:0] want [3];
        int k = 0;
        want[0] = 24'hAAAAAA; want[1] = 24'h555555; want[2] = 24'hAAAAAA;
        memwr(3'd0, 1'b0, 24'hAAAAAA);
        memwr(3'd0, 1'b1, 24'h555555);
        cfg(3'd0, 1'b1, 1'b0);
        restart = 1'b1; en = 1'b1; tick(); restart = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            n_total++;
            if (conf_valid !== exp_v || conf_thread !== cur.thr || (cur.known && conf_out !== cur.data))
                $display("FAIL alt_sb got v=%b thr=%0d out=%h exp v=%b thr=%0d out=%h", conf_valid, conf_thread, conf_out, exp_v, cur.thr, cur.data);
            else n_pass++;
            if (exp_v && cur.thr == 3'd0 && k < 3) begin
                n_total++;
                if (conf_out !== want[k]) $display("FAIL alt_t0_%0d got %h exp %h", k, conf_out, want[k]);
                else n_pass++;
                k++;
            end
        end
        en = 1'b0; tick();
    endtask

    task automatic test_thread3_pinned();
        memwr(3'd3, 1'b0, 24'h123456);
        cfg(3'd3, 1'b0, 1'b0);
        restart = 1'b1; en = 1'b1; tick(); restart = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            n_total++;
            if (conf_valid !== exp_v || conf_thread !== cur.thr || (cur.known && conf_out !== cur.data))
                $display("FAIL pin_sb got v=%b thr=%0d out=%h exp thr=%0d out=%h", conf_valid, conf_thread, conf_out, cur.thr, cur.data);
            else n_pass++;
            if (exp_v && cur.thr == 3'd3) begin
                n_total++;
                if (conf_out !== 24'h123456) $display("FAIL pin_t3 got %h exp 123456", conf_out);
                else n_pass++;
            end
        end
        en = 1'b0; tick();
    endtask

    task automatic test_read_before_write();
        logic [23:0] want [3];
        int k = 0;
        want[0] = 24'hAAAAAA; want[1] = 24'h555555; want[2] = 24'hFFFFFF;
        restart = 1'b1; en = 1'b1; tick(); restart = 1'b0;
        thread_id = 3'd0; net_mem_waddr = 1'b0; net_mem_data = 24'hFFFFFF; net_mem_we = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            net_mem_we = 1'b0;
            n_total++;
            if (conf_valid !== exp_v || conf_thread !== cur.thr || (cur.known && conf_out !== cur.data))
                $display("FAIL rbw_sb got v=%b thr=%0d out=%h exp thr=%0d out=%h", conf_valid, conf_thread, conf_out, cur.thr, cur.data);
            else n_pass++;
            if (exp_v && cur.thr == 3'd0 && k < 3) begin
                n_total++;
                if (conf_out !== want[k]) $display("FAIL rbw_t0_%0d got %h exp %h", k, conf_out, want[k]);
                else n_pass++;
                k++;
            end
        end
        en = 1'b0; tick();
    endtask

    task automatic test_pause();
        restart = 1'b1; en = 1'b1; tick(); restart = 1'b0;
        for (int i = 0; i < 10; i++) begin
            en = (i < 3 || i >= 8);
            tick();
            n_total++;
            if (conf_valid !== exp_v || (exp_v && (conf_thread !== cur.thr || (cur.known && conf_out !== cur.data))))
                $display("FAIL pause_sb[%0d] got v=%b thr=%0d out=%h exp v=%b thr=%0d", i, conf_valid, conf_thread, conf_out, exp_v, cur.thr);
            else n_pass++;
            if (i == 8) begin
                n_total++;
                if (conf_valid !== 1'b1 || conf_thread !== 3'd3 || conf_out !== 24'h123456)
                    $display("FAIL pause_resume got v=%b thr=%0d out=%h exp v=1 thr=3 out=123456", conf_valid, conf_thread, conf_out);
                else n_pass++;
            end
        end
        en = 1'b0; tick();
    endtask

    task automatic test_config_during_run();
        cfg(3'd5, 1'b0, 1'b1);
        restart = 1'b1; en = 1'b1; tick(); restart = 1'b0;
        thread_id = 3'd0; pc_max = 1'b0; pc_max_we = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            pc_max_we = 1'b0;
            n_total++;
            if (conf_valid !== exp_v || conf_thread !== cur.thr || (cur.known && conf_out !== cur.data))
                $display("FAIL cfgrun_sb got v=%b thr=%0d out=%h exp thr=%0d out=%h", conf_valid, conf_thread, conf_out, cur.thr, cur.data);
            else n_pass++;
            if (i == 8) begin
                n_total++;
                if (conf_thread !== 3'd0 || conf_out !== 24'h555555)
                    $display("FAIL cfgrun_oldmax got thr=%0d out=%h exp thr=0 out=555555", conf_thread, conf_out);
                else n_pass++;
            end
        end
        en = 1'b0; tick();
        cfg(3'd0, 1'b1, 1'b0);
    endtask

    task automatic test_restart();
        en = 1'b1;
        repeat (5) tick();
        restart = 1'b1; tick(); restart = 1'b0;
        n_total++;
        if (conf_valid !== 1'b0) $display("FAIL restart_valid got %b exp 0", conf_valid);
        else n_pass++;
        tick();
        n_total++;
        if (conf_valid !== 1'b1 || conf_thread !== 3'd0 || conf_out !== 24'hFFFFFF)
            $display("FAIL restart_first got v=%b thr=%0d out=%h exp v=1 thr=0 out=ffffff", conf_valid, conf_thread, conf_out);
        else n_pass++;
        en = 1'b0; tick();
    endtask

    task automatic test_async_reset();
        logic [23:0] want [2];
        int k = 0;
        want[0] = 24'hFFFFFF; want[1] = 24'h555555;
        en = 1'b1;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (conf_valid !== 1'b0 || conf_out !== 24'h0 || conf_thread !== 3'd0)
            $display("FAIL async_rst got v=%b out=%h thr=%0d exp v=0 out=000000 thr=0", conf_valid, conf_out, conf_thread);
        else n_pass++;
        en = 1'b0;
        model_clear();
        @(posedge clk); #1 rst = 1'b0;
        cfg(3'd0, 1'b1, 1'b0);
        cfg(3'd5, 1'b0, 1'b1);
        en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            n_total++;
            if (conf_valid !== exp_v || conf_thread !== cur.thr || (cur.known && conf_out !== cur.data))
                $display("FAIL post_rst_sb got v=%b thr=%0d out=%h exp thr=%0d out=%h", conf_valid, conf_thread, conf_out, cur.thr, cur.data);
            else n_pass++;
            if (exp_v && cur.thr == 3'd0 && k < 2) begin
                n_total++;
                if (conf_out !== want[k]) $display("FAIL post_rst_t0_%0d got %h exp %h", k, conf_out, want[k]);
                else n_pass++;
                k++;
            end
            if (exp_v && cur.thr == 3'd3) begin
                n_total++;
                if (conf_out !== 24'h123456) $display("FAIL post_rst_t3 got %h exp 123456", conf_out);
                else n_pass++;
            end
        end
        en = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_preload();
        test_round_robin();
        test_thread0_alternate();
        test_thread3_pinned();
        test_read_before_write();
        test_pause();
        test_config_during_run();
        test_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
